mem_lsu: RTL

Load/store unit for the MEM stage of the pipelined processor: the initiator that drives the word-organised data RAM on behalf of the pipeline. Converts byte-addressed word/halfword/byte loads and stores from the pipeline into word accesses on the RAM port. Extracts and sign/zero-extends loaded sub-words. Implements sub-word stores as a two-cycle read-modify-write, stalling the pipeline for one cycle.

---
 rtl/mem_lsu.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns byte-addressed word/half/byte accesses into
// word accesses on a single-port RAM, with read-modify-write for sub-word stores.
module mem_lsu #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [1:0]        SizeM,
   input  logic              SignedM,
   input  logic [31:0]       AddrM,
   input  logic [31:0]       StoreDataM,
   output logic [31:0]       LoadDataM,
   output logic              StallM,
   output logic              MisalignM,
   output logic              RamWE,
   output logic [ADDR_W-1:0] RamAddr,
   output logic [31:0]       RamWData,
   input  logic [31:0]       RamRData
);

   typedef enum logic {IDLE, MERGE} stateType;

   stateType          state;
   logic [31:0]       rmwWord;
   logic [ADDR_W-1:0] latAddr;
   logic [1:0]        latLane;
   logic              latHalf;
   logic [15:0]       latData;

   logic [ADDR_W-1:0] wordAddr;
   logic [1:0]        lane;
   logic              isReq;
   logic              badAlign;
   logic              isWord;
   logic              subStore;
   logic [7:0]        byteSel;
   logic [15:0]       halfSel;
   logic [31:0]       loadExt;
   logic [31:0]       mergedWord;
   logic              unusedAddrBits;

   // Address bits above the RAM depth are deliberately dropped (wrap-around).
   assign unusedAddrBits = &{1'b0, AddrM[31:ADDR_W+2]};

   assign wordAddr = AddrM[ADDR_W+1:2];
   assign lane     = AddrM[1:0];
   assign isReq    = MemReadM | MemWriteM;
   assign isWord   = (SizeM == 2'b10);
   assign badAlign = (SizeM == 2'b11)
                   | ((SizeM == 2'b01) & AddrM[0])
                   | (isWord & (|AddrM[1:0]));
   assign subStore = MemWriteM & ~badAlign & ~isWord;

   // Lane extraction and extension for loads.
   always_comb begin
      byteSel = RamRData[{lane, 3'b000} +: 8];
      halfSel = RamRData[{lane[1], 4'b0000} +: 16];
      case (SizeM)
         2'b00:   loadExt = {{24{SignedM & byteSel[7]}}, byteSel};
         2'b01:   loadExt = {{16{SignedM & halfSel[15]}}, halfSel};
         default: loadExt = RamRData;
      endcase
   end

   always_comb begin
      mergedWord = rmwWord;
      if (latHalf) mergedWord[{latLane[1], 4'b0000} +: 16] = latData;
      else         mergedWord[{latLane, 3'b000} +: 8]      = latData[7:0];
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      LoadDataM = '0;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      RamWE     = 1'b0;
      RamAddr   = '0;
      RamWData  = '0;
      if (!reset) begin
         case (state)
            IDLE: begin
               RamAddr = wordAddr;
               if (isReq && badAlign) begin
                  MisalignM = 1'b1;
               end else begin
                  if (MemReadM) LoadDataM = loadExt;
                  if (MemWriteM && isWord) begin
                     RamWE    = 1'b1;
                     RamWData = StoreDataM;
                  end else if (MemWriteM) begin
                     StallM = 1'b1;
                  end
               end
            end
            MERGE: begin
               RamWE    = 1'b1;
               RamAddr  = latAddr;
               RamWData = mergedWord;
            end
            default: ;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rmwWord <= '0;
         latAddr <= '0;
         latLane <= '0;
         latHalf <= 1'b0;
         latData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (subStore) begin
                  state   <= MERGE;
                  rmwWord <= RamRData;
                  latAddr <= wordAddr;
                  latLane <= lane;
                  latHalf <= SizeM[0];
                  latData <= StoreDataM[15:0];
               end
            end
            // The pipeline still holds the stalled request here, so inputs are ignored.
            MERGE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
